// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioner bank.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debounce FSM, press/release/repeat strobes.
//
// state        | meaning
// IDLE         | stable released
// PRESS_WAIT   | input pressed, waiting for it to stay pressed long enough
// HELD         | stable pressed, repeat timer running
// RELEASE_WAIT | input released, waiting to confirm; repeat timer frozen
module btn_chan
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press_stb,
    output logic o_release_stb,
    output logic o_repeat_stb
);

    localparam int DEB_MAX   = DEBOUNCE_CYCLES - 1;
    localparam int DELAY_MAX = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int PER_MAX   = REPEAT_PERIOD - 1;
    localparam int REP_MAX   = (DELAY_MAX > PER_MAX) ? DELAY_MAX : PER_MAX;
    localparam int DEB_W     = cnt_width(DEB_MAX);
    localparam int REP_W     = cnt_width(REP_MAX);

    localparam logic [DEB_W-1:0] DEB_LOAD   = DEB_W'(DEB_MAX);
    localparam logic [REP_W-1:0] DELAY_LOAD = REP_W'(DELAY_MAX);
    localparam logic [REP_W-1:0] PER_LOAD   = REP_W'(PER_MAX);
    localparam logic             REP_EN     = (REPEAT_DELAY != 0);
    localparam logic             INV        = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    btn_state_t             r_state;
    logic [DEB_W-1:0]       r_deb;
    logic [REP_W-1:0]       r_rep;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn ^ INV};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Both timers are down-counters loaded with (span - 1) and fire on zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_deb         <= '0;
            r_rep         <= '0;
            o_level       <= 1'b0;
            o_press_stb   <= 1'b0;
            o_release_stb <= 1'b0;
            o_repeat_stb  <= 1'b0;
        end else begin
            o_press_stb   <= 1'b0;
            o_release_stb <= 1'b0;
            o_repeat_stb  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= PRESS_WAIT;
                        r_deb   <= DEB_LOAD;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_deb == '0) begin
                        r_state     <= HELD;
                        o_level     <= 1'b1;
                        o_press_stb <= 1'b1;
                        r_rep       <= DELAY_LOAD;
                    end else begin
                        r_deb <= r_deb - 1'b1;
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_deb   <= DEB_LOAD;
                    end
                    // An expiry on the cycle the input drops is held at zero
                    // and fires once the press is confirmed again.
                    if (REP_EN) begin
                        if (r_rep != '0) begin
                            r_rep <= r_rep - 1'b1;
                        end else if (w_s) begin
                            o_repeat_stb <= 1'b1;
                            r_rep        <= PER_LOAD;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= HELD;
                    end else if (r_deb == '0) begin
                        r_state       <= IDLE;
                        o_level       <= 1'b0;
                        o_release_stb <= 1'b1;
                    end else begin
                        r_deb <= r_deb - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_bank.sv
// Bank of independent button conditioners sharing one clock and reset.
module btn_bank
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press_stb,
    output logic [N_BTN-1:0] o_release_stb,
    output logic [N_BTN-1:0] o_repeat_stb
);

    if (N_BTN < 1) begin : g_bad_n_btn
        $error("btn_bank: N_BTN must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_bank: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_bank: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 0) begin : g_bad_delay
        $error("btn_bank: REPEAT_DELAY must be >= 0");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("btn_bank: REPEAT_PERIOD must be >= 1");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_polarity
        $error("btn_bank: ACTIVE_LOW must be 0 or 1");
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_btn         (i_btn[g]),
            .o_level       (o_level[g]),
            .o_press_stb   (o_press_stb[g]),
            .o_release_stb (o_release_stb[g]),
            .o_repeat_stb  (o_repeat_stb[g])
        );
    end

endmodule

// File: tb/tb_btn_bank.sv
// Scoreboard bench: an active-high and an active-low bank get the same logical
// stimulus and must produce the same hand-computed strobe schedule.
module tb_btn_bank;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] t;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [2:0] btn_n;
    logic [2:0] lvl0, p0, r0, t0;
    logic [2:0] lvl1, p1, r1, t1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        q[2][$];

    assign btn_n = ~btn;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_bank #(.N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
               .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .ACTIVE_LOW(0)) u_dut_hi (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_level(lvl0), .o_press_stb(p0), .o_release_stb(r0), .o_repeat_stb(t0));

    btn_bank #(.N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
               .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .ACTIVE_LOW(1)) u_dut_lo (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_n),
        .o_level(lvl1), .o_press_stb(p1), .o_release_stb(r1), .o_repeat_stb(t1));

    task automatic sync_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_ev(input int c, input logic [2:0] p, input logic [2:0] r,
                             input logic [2:0] t);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.t = t;
        q[0].push_back(e);
        q[1].push_back(e);
    endtask

    task automatic chk_lvl(input string nm, input logic [2:0] exp);
        checks++;
        if (lvl0 !== exp) begin
            failures++;
            $display("FAIL %s dut_hi cycle %0d level=%b expected=%b", nm, cyc, lvl0, exp);
        end
        checks++;
        if (lvl1 !== exp) begin
            failures++;
            $display("FAIL %s dut_lo cycle %0d level=%b expected=%b", nm, cyc, lvl1, exp);
        end
    endtask

    task automatic mon(input int d, input logic [2:0] p, input logic [2:0] r,
                       input logic [2:0] t);
        ev_t e;
        if ((p | r | t) != 3'b000) begin
            checks++;
            if (q[d].size() == 0) begin
                failures++;
                $display("FAIL strobe_dut%0d unexpected at cycle %0d p=%b r=%b t=%b",
                         d, cyc, p, r, t);
            end else begin
                e = q[d].pop_front();
                if (e.cyc != cyc || e.p !== p || e.r !== r || e.t !== t) begin
                    failures++;
                    $display("FAIL strobe_dut%0d got cycle %0d p=%b r=%b t=%b expected cycle %0d p=%b r=%b t=%b",
                             d, cyc, p, r, t, e.cyc, e.p, e.r, e.t);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, p0, r0, t0);
        mon(1, p1, r1, t1);
    end

    initial begin
        ev_t e;
        // reset held through edges 1..3
        sync_to(3);
        chk_lvl("reset_level", 3'b000);
        checks++;
        if ((p0 | r0 | t0 | p1 | r1 | t1) !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes hi=%b/%b/%b lo=%b/%b/%b expected all 0",
                     p0, r0, t0, p1, r1, t1);
        end
        rst = 1'b0;

        // clean press on ch0 sampled from edge 10, release from edge 40
        sync_to(9);  btn[0] = 1'b1;
        expect_ev(16, 3'b001, 3'b000, 3'b000);
        expect_ev(36, 3'b000, 3'b000, 3'b001);
        sync_to(15); chk_lvl("press_before", 3'b000);
        sync_to(16); chk_lvl("press_level", 3'b001);
        sync_to(39); btn[0] = 1'b0;
        expect_ev(46, 3'b000, 3'b001, 3'b000);
        sync_to(45); chk_lvl("release_before", 3'b001);
        sync_to(46); chk_lvl("release_level", 3'b000);

        // 3-cycle glitch on ch0 (edges 60..62)
        sync_to(59); btn[0] = 1'b1;
        sync_to(62); btn[0] = 1'b0;
        sync_to(68); chk_lvl("glitch_level", 3'b000);

        // ch1 bounces 1,0,1,0 then holds from edge 74
        sync_to(69); btn[1] = 1'b1;
        sync_to(70); btn[1] = 1'b0;
        sync_to(71); btn[1] = 1'b1;
        sync_to(72); btn[1] = 1'b0;
        sync_to(73); btn[1] = 1'b1;
        expect_ev(80, 3'b010, 3'b000, 3'b000);
        sync_to(79); chk_lvl("bounce_before", 3'b000);
        sync_to(80); chk_lvl("bounce_level", 3'b010);
        sync_to(89); btn[1] = 1'b0;
        expect_ev(96, 3'b000, 3'b010, 3'b000);
        sync_to(96); chk_lvl("bounce_release", 3'b000);

        // ch2 long hold with repeats, then bouncy release
        sync_to(109); btn[2] = 1'b1;
        expect_ev(116, 3'b100, 3'b000, 3'b000);
        for (int k = 0; k < 5; k++) expect_ev(136 + 8 * k, 3'b000, 3'b000, 3'b100);
        expect_ev(180, 3'b000, 3'b100, 3'b000);
        sync_to(116); chk_lvl("hold_level", 3'b100);
        sync_to(169); btn[2] = 1'b0;
        sync_to(171); btn[2] = 1'b1;
        sync_to(173); btn[2] = 1'b0;
        sync_to(179); chk_lvl("bouncy_release_before", 3'b100);
        sync_to(180); chk_lvl("bouncy_release_level", 3'b000);

        // all channels together, then reset while held
        sync_to(199); btn = 3'b111;
        expect_ev(206, 3'b111, 3'b000, 3'b000);
        sync_to(206); chk_lvl("simul_level", 3'b111);
        sync_to(209); rst = 1'b1;
        sync_to(210); chk_lvl("rst_held_level", 3'b000);
        sync_to(211); rst = 1'b0;
        expect_ev(218, 3'b111, 3'b000, 3'b000);
        sync_to(217); chk_lvl("redetect_before", 3'b000);
        sync_to(218); chk_lvl("redetect_level", 3'b111);
        sync_to(229); btn = 3'b000;
        expect_ev(236, 3'b000, 3'b111, 3'b000);
        sync_to(236); chk_lvl("final_release", 3'b000);

        sync_to(260);
        for (int d = 0; d < 2; d++) begin
            while (q[d].size() > 0) begin
                e = q[d].pop_front();
                checks++;
                failures++;
                $display("FAIL strobe_dut%0d missing expected cycle %0d p=%b r=%b t=%b",
                         d, e.cyc, e.p, e.r, e.t);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
